// File: rtl/slc3_pkg.sv
// Shared definitions for the SLC-3 control unit and datapath: FSM state type,
// opcode constants, mux/ALU select encodings and the per-state control word.
package slc3_pkg;

  typedef enum logic [4:0] {
    StHalted,
    StFetch1,
    StFetch2A,
    StFetch2B,
    StFetch2C,
    StFetch3,
    StDecode,
    StAdd,
    StAnd,
    StNot,
    StBr,
    StBrTaken,
    StJmp,
    StJsr,
    StJsrReg,
    StJsrOff,
    StLdr1,
    StLdr2A,
    StLdr2B,
    StLdr2C,
    StLdr3,
    StStr1,
    StStr2,
    StStr3A,
    StStr3B,
    StStr3C,
    StPause1,
    StPause2
  } state_e;

  // Opcodes (IR[15:12])
  localparam logic [3:0] OpBr    = 4'b0000;
  localparam logic [3:0] OpAdd   = 4'b0001;
  localparam logic [3:0] OpJsr   = 4'b0100;
  localparam logic [3:0] OpAnd   = 4'b0101;
  localparam logic [3:0] OpLdr   = 4'b0110;
  localparam logic [3:0] OpStr   = 4'b0111;
  localparam logic [3:0] OpNot   = 4'b1001;
  localparam logic [3:0] OpJmp   = 4'b1100;
  localparam logic [3:0] OpPause = 4'b1101;

  // PC source
  localparam logic [1:0] PcmuxInc   = 2'b00;
  localparam logic [1:0] PcmuxBus   = 2'b01;
  localparam logic [1:0] PcmuxAdder = 2'b10;

  // Address adder, second operand
  localparam logic [1:0] Addr2Zero  = 2'b00;
  localparam logic [1:0] Addr2Off6  = 2'b01;
  localparam logic [1:0] Addr2Off9  = 2'b10;
  localparam logic [1:0] Addr2Off11 = 2'b11;

  // ALU function
  localparam logic [1:0] AlukAdd   = 2'b00;
  localparam logic [1:0] AlukAnd   = 2'b01;
  localparam logic [1:0] AlukNot   = 2'b10;
  localparam logic [1:0] AlukPassA = 2'b11;

  // Single-bit selects
  localparam logic Addr1Pc  = 1'b0;
  localparam logic Addr1Sr1 = 1'b1;
  localparam logic DrIr119  = 1'b0;
  localparam logic DrR7     = 1'b1;
  localparam logic Sr1Ir119 = 1'b0;
  localparam logic Sr1Ir86  = 1'b1;

  // Control word; sr2_ir5 marks states where SR2MUX follows IR[5]
  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_cc;
    logic       ld_reg;
    logic       ld_pc;
    logic       ld_led;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic       sr2_ir5;
    logic       addr1mux;
    logic       drmux;
    logic       sr1mux;
    logic       mem_oe;
    logic       mem_we;
    logic [1:0] pcmux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
  } ctrl_t;

  // Moore output decode: everything not listed for a state stays zero.
  function automatic ctrl_t state_ctrl(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      StFetch1: begin
        c.gate_pc = 1'b1;
        c.ld_mar  = 1'b1;
        c.ld_pc   = 1'b1;
        c.pcmux   = PcmuxInc;
      end
      StFetch2A, StFetch2B, StLdr2A, StLdr2B: c.mem_oe = 1'b1;
      StFetch2C, StLdr2C: begin
        c.mem_oe = 1'b1;
        c.ld_mdr = 1'b1;
      end
      StFetch3: begin
        c.gate_mdr = 1'b1;
        c.ld_ir    = 1'b1;
      end
      StDecode: c.ld_ben = 1'b1;
      StAdd, StAnd: begin
        c.sr1mux   = Sr1Ir86;
        c.sr2_ir5  = 1'b1;
        c.aluk     = (s == StAnd) ? AlukAnd : AlukAdd;
        c.gate_alu = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      StNot: begin
        c.sr1mux   = Sr1Ir86;
        c.aluk     = AlukNot;
        c.gate_alu = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      StBrTaken: begin
        c.addr1mux = Addr1Pc;
        c.addr2mux = Addr2Off9;
        c.pcmux    = PcmuxAdder;
        c.ld_pc    = 1'b1;
      end
      StJmp, StJsrReg: begin
        c.sr1mux   = Sr1Ir86;
        c.addr1mux = Addr1Sr1;
        c.addr2mux = Addr2Zero;
        c.pcmux    = PcmuxAdder;
        c.ld_pc    = 1'b1;
      end
      StJsr: begin
        c.gate_pc = 1'b1;
        c.drmux   = DrR7;
        c.ld_reg  = 1'b1;
      end
      StJsrOff: begin
        c.addr1mux = Addr1Pc;
        c.addr2mux = Addr2Off11;
        c.pcmux    = PcmuxAdder;
        c.ld_pc    = 1'b1;
      end
      StLdr1, StStr1: begin
        c.sr1mux      = Sr1Ir86;
        c.addr1mux    = Addr1Sr1;
        c.addr2mux    = Addr2Off6;
        c.gate_marmux = 1'b1;
        c.ld_mar      = 1'b1;
      end
      StLdr3: begin
        c.gate_mdr = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      StStr2: begin
        c.sr1mux   = Sr1Ir119;
        c.aluk     = AlukPassA;
        c.gate_alu = 1'b1;
        c.ld_mdr   = 1'b1;
      end
      StStr3A, StStr3B, StStr3C: c.mem_we = 1'b1;
      StPause1: c.ld_led = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/slc3_control.sv
// SLC-3 control unit: Moore FSM sequencing fetch, decode and execute.
// The control word is registered alongside the state (decoded from the state
// being entered), so outputs track the current state with no decode glitches
// and drop to zero the instant Reset is asserted.
module slc3_control
  import slc3_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic [1:0] PCMUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  // Next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHalted:  state_d = Run ? StFetch1 : StHalted;
      StFetch1:  state_d = StFetch2A;
      StFetch2A: state_d = StFetch2B;
      StFetch2B: state_d = StFetch2C;
      StFetch2C: state_d = StFetch3;
      StFetch3:  state_d = StDecode;
      StDecode: begin
        case (Opcode)
          OpAdd:   state_d = StAdd;
          OpAnd:   state_d = StAnd;
          OpNot:   state_d = StNot;
          OpBr:    state_d = StBr;
          OpJmp:   state_d = StJmp;
          OpJsr:   state_d = StJsr;
          OpLdr:   state_d = StLdr1;
          OpStr:   state_d = StStr1;
          OpPause: state_d = StPause1;
          default: state_d = StFetch1;
        endcase
      end
      StBr:      state_d = BEN ? StBrTaken : StFetch1;
      StJsr:     state_d = IR_11 ? StJsrOff : StJsrReg;
      StLdr1:    state_d = StLdr2A;
      StLdr2A:   state_d = StLdr2B;
      StLdr2B:   state_d = StLdr2C;
      StLdr2C:   state_d = StLdr3;
      StStr1:    state_d = StStr2;
      StStr2:    state_d = StStr3A;
      StStr3A:   state_d = StStr3B;
      StStr3B:   state_d = StStr3C;
      StPause1:  state_d = Continue ? StPause2 : StPause1;
      StPause2:  state_d = Continue ? StPause2 : StFetch1;
      StAdd, StAnd, StNot, StBrTaken, StJmp, StJsrReg, StJsrOff, StLdr3, StStr3C:
        state_d = StFetch1;
      default:   state_d = StHalted;
    endcase
  end

  // Control word for the state being entered; LD_LED only on entry to PAUSE1
  always_comb begin
    ctrl_d = state_ctrl(state_d);
    if (state_q == StPause1) begin
      ctrl_d.ld_led = 1'b0;
    end
  end

  // State register and registered control word
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StHalted;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign LD_MAR     = ctrl_q.ld_mar;
  assign LD_MDR     = ctrl_q.ld_mdr;
  assign LD_IR      = ctrl_q.ld_ir;
  assign LD_BEN     = ctrl_q.ld_ben;
  assign LD_CC      = ctrl_q.ld_cc;
  assign LD_REG     = ctrl_q.ld_reg;
  assign LD_PC      = ctrl_q.ld_pc;
  assign LD_LED     = ctrl_q.ld_led;
  assign GatePC     = ctrl_q.gate_pc;
  assign GateMDR    = ctrl_q.gate_mdr;
  assign GateALU    = ctrl_q.gate_alu;
  assign GateMARMUX = ctrl_q.gate_marmux;
  // Register vs. immediate operand is picked straight from IR[5]
  assign SR2MUX     = ctrl_q.sr2_ir5 & IR_5;
  assign ADDR1MUX   = ctrl_q.addr1mux;
  assign DRMUX      = ctrl_q.drmux;
  assign SR1MUX     = ctrl_q.sr1mux;
  assign Mem_OE     = ctrl_q.mem_oe;
  assign Mem_WE     = ctrl_q.mem_we;
  assign PCMUX      = ctrl_q.pcmux;
  assign ADDR2MUX   = ctrl_q.addr2mux;
  assign ALUK       = ctrl_q.aluk;

endmodule

// File: tb/tb_slc3_control.sv
// Bench for slc3_control: directed instruction table with per-instruction
// summary counts, hand-written reset/pause sequences, and random instruction
// streams checked cycle by cycle against an instruction-level trace model.
module tb_slc3_control;

  logic       Clk = 1'b0;
  logic       Reset, Run, Continue, IR_5, IR_11, BEN;
  logic [3:0] Opcode;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic       SR2MUX, ADDR1MUX, DRMUX, SR1MUX, Mem_OE, Mem_WE;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;

  slc3_control dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Run        (Run),
    .Continue   (Continue),
    .Opcode     (Opcode),
    .IR_5       (IR_5),
    .IR_11      (IR_11),
    .BEN        (BEN),
    .LD_MAR     (LD_MAR),
    .LD_MDR     (LD_MDR),
    .LD_IR      (LD_IR),
    .LD_BEN     (LD_BEN),
    .LD_CC      (LD_CC),
    .LD_REG     (LD_REG),
    .LD_PC      (LD_PC),
    .LD_LED     (LD_LED),
    .GatePC     (GatePC),
    .GateMDR    (GateMDR),
    .GateALU    (GateALU),
    .GateMARMUX (GateMARMUX),
    .SR2MUX     (SR2MUX),
    .ADDR1MUX   (ADDR1MUX),
    .DRMUX      (DRMUX),
    .SR1MUX     (SR1MUX),
    .Mem_OE     (Mem_OE),
    .Mem_WE     (Mem_WE),
    .PCMUX      (PCMUX),
    .ADDR2MUX   (ADDR2MUX),
    .ALUK       (ALUK)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic       sr2mux, addr1mux, drmux, sr1mux, mem_oe, mem_we;
    logic [1:0] pcmux, addr2mux, aluk;
  } obs_t;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic       ir5, ir11, ben;
    int         exec_len, n_reg, n_pc, n_we, n_oe, n_sr2, n_cc;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t exp_q[$];
  logic cont_q[$];
  vec_t vecs[$];

  function automatic obs_t observe();
    obs_t o;
    o.ld_mar = LD_MAR;   o.ld_mdr = LD_MDR;     o.ld_ir = LD_IR;       o.ld_ben = LD_BEN;
    o.ld_cc = LD_CC;     o.ld_reg = LD_REG;     o.ld_pc = LD_PC;       o.ld_led = LD_LED;
    o.gate_pc = GatePC;  o.gate_mdr = GateMDR;  o.gate_alu = GateALU;  o.gate_marmux = GateMARMUX;
    o.sr2mux = SR2MUX;   o.addr1mux = ADDR1MUX; o.drmux = DRMUX;       o.sr1mux = SR1MUX;
    o.mem_oe = Mem_OE;   o.mem_we = Mem_WE;     o.pcmux = PCMUX;       o.addr2mux = ADDR2MUX;
    o.aluk = ALUK;
    return o;
  endfunction

  function automatic obs_t fetch1_obs();
    obs_t o;
    o = '0;
    o.gate_pc = 1'b1; o.ld_mar = 1'b1; o.ld_pc = 1'b1; o.pcmux = 2'b00;
    return o;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_obs(input string name, input obs_t exp);
    obs_t got;
    got = observe();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic push(input obs_t o, input logic c);
    exp_q.push_back(o);
    cont_q.push_back(c);
  endtask

  // Expected per-cycle outputs of one instruction, from the cycle after FETCH1
  // up to and including the next FETCH1. cont_q holds the Continue value to
  // drive on the edge that enters each cycle. pk/pm = cycles in PAUSE1/PAUSE2.
  task automatic build_trace(input logic [3:0] op, input logic ir5, input logic ir11,
                             input logic ben, input int pk, input int pm);
    obs_t o;
    exp_q.delete();
    cont_q.delete();
    o = '0; o.mem_oe = 1'b1;
    push(o, 1'($urandom_range(0, 1)));
    push(o, 1'($urandom_range(0, 1)));
    o.ld_mdr = 1'b1;
    push(o, 1'($urandom_range(0, 1)));
    o = '0; o.gate_mdr = 1'b1; o.ld_ir = 1'b1;
    push(o, 1'($urandom_range(0, 1)));
    o = '0; o.ld_ben = 1'b1;
    push(o, 1'($urandom_range(0, 1)));
    o = '0;
    case (op)
      4'b0001, 4'b0101: begin
        o.sr1mux = 1'b1; o.sr2mux = ir5; o.aluk = (op == 4'b0101) ? 2'd1 : 2'd0;
        o.gate_alu = 1'b1; o.ld_reg = 1'b1; o.ld_cc = 1'b1;
        push(o, 1'($urandom_range(0, 1)));
      end
      4'b1001: begin
        o.sr1mux = 1'b1; o.aluk = 2'd2; o.gate_alu = 1'b1; o.ld_reg = 1'b1; o.ld_cc = 1'b1;
        push(o, 1'($urandom_range(0, 1)));
      end
      4'b0000: begin
        push(o, 1'($urandom_range(0, 1)));
        if (ben) begin
          o.addr2mux = 2'd2; o.pcmux = 2'd2; o.ld_pc = 1'b1;
          push(o, 1'($urandom_range(0, 1)));
        end
      end
      4'b1100: begin
        o.sr1mux = 1'b1; o.addr1mux = 1'b1; o.pcmux = 2'd2; o.ld_pc = 1'b1;
        push(o, 1'($urandom_range(0, 1)));
      end
      4'b0100: begin
        o.gate_pc = 1'b1; o.drmux = 1'b1; o.ld_reg = 1'b1;
        push(o, 1'($urandom_range(0, 1)));
        o = '0; o.pcmux = 2'd2; o.ld_pc = 1'b1;
        if (ir11) begin
          o.addr2mux = 2'd3;
        end else begin
          o.sr1mux = 1'b1; o.addr1mux = 1'b1;
        end
        push(o, 1'($urandom_range(0, 1)));
      end
      4'b0110, 4'b0111: begin
        o.sr1mux = 1'b1; o.addr1mux = 1'b1; o.addr2mux = 2'd1; o.gate_marmux = 1'b1;
        o.ld_mar = 1'b1;
        push(o, 1'($urandom_range(0, 1)));
        o = '0;
        if (op == 4'b0110) begin
          o.mem_oe = 1'b1;
          push(o, 1'($urandom_range(0, 1)));
          push(o, 1'($urandom_range(0, 1)));
          o.ld_mdr = 1'b1;
          push(o, 1'($urandom_range(0, 1)));
          o = '0; o.gate_mdr = 1'b1; o.ld_reg = 1'b1; o.ld_cc = 1'b1;
          push(o, 1'($urandom_range(0, 1)));
        end else begin
          o.aluk = 2'd3; o.gate_alu = 1'b1; o.ld_mdr = 1'b1;
          push(o, 1'($urandom_range(0, 1)));
          o = '0; o.mem_we = 1'b1;
          for (int i = 0; i < 3; i++) push(o, 1'($urandom_range(0, 1)));
        end
      end
      4'b1101: begin
        o.ld_led = 1'b1;
        push(o, 1'($urandom_range(0, 1)));
        o = '0;
        for (int i = 1; i < pk; i++) push(o, 1'b0);
        for (int i = 0; i < pm; i++) push(o, 1'b1);
      end
      default: ;
    endcase
    push(fetch1_obs(), 1'b0);
  endtask

  // Apply the current trace; Run is randomised since it must be ignored here.
  task automatic run_trace(input string name);
    int gates;
    for (int i = 0; i < exp_q.size(); i++) begin
      Continue = cont_q[i];
      Run      = 1'($urandom_range(0, 1));
      tick();
      check_obs($sformatf("%s_cyc%0d", name, i + 1), exp_q[i]);
      gates = $countones({GatePC, GateMDR, GateALU, GateMARMUX});
      check_int({name, "_gate_onehot"}, (gates <= 1) ? 1 : 0, 1);
    end
  endtask

  // Directed row: starting in FETCH1, count control activity between DECODE
  // and the next FETCH1.
  task automatic run_vec(input vec_t v);
    obs_t o;
    int   len, nreg, npc, nwe, noe, nsr2, ncc;
    bit   found;
    Opcode = v.op; IR_5 = v.ir5; IR_11 = v.ir11; BEN = v.ben; Continue = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Run = 1'($urandom_range(0, 1));
      tick();
    end
    check_int({v.name, "_decode_ld_ben"}, int'(LD_BEN), 1);
    len = 0; nreg = 0; npc = 0; nwe = 0; noe = 0; nsr2 = 0; ncc = 0; found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      tick();
      o = observe();
      if (o.gate_pc && o.ld_mar && o.ld_pc) begin
        found = 1'b1;
      end else begin
        len++;
        nreg += int'(o.ld_reg); npc += int'(o.ld_pc); nwe += int'(o.mem_we);
        noe += int'(o.mem_oe);  nsr2 += int'(o.sr2mux); ncc += int'(o.ld_cc);
      end
    end
    check_int({v.name, "_back_to_fetch"}, int'(found), 1);
    check_int({v.name, "_exec_len"}, len, v.exec_len);
    check_int({v.name, "_ld_reg"}, nreg, v.n_reg);
    check_int({v.name, "_ld_pc"}, npc, v.n_pc);
    check_int({v.name, "_mem_we"}, nwe, v.n_we);
    check_int({v.name, "_mem_oe"}, noe, v.n_oe);
    check_int({v.name, "_sr2mux"}, nsr2, v.n_sr2);
    check_int({v.name, "_ld_cc"}, ncc, v.n_cc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op;
    int         pk, pm;

    //                name        op       ir5   ir11  ben  len reg pc we oe sr2 cc
    vecs.push_back('{"add_reg",  4'b0001, 1'b0, 1'b0, 1'b0, 1, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{"add_imm",  4'b0001, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0, 1, 1});
    vecs.push_back('{"and_imm",  4'b0101, 1'b1, 1'b1, 1'b1, 1, 1, 0, 0, 0, 1, 1});
    vecs.push_back('{"and_reg",  4'b0101, 1'b0, 1'b0, 1'b0, 1, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{"not",      4'b1001, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{"br_nt",    4'b0000, 1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"br_t",     4'b0000, 1'b0, 1'b0, 1'b1, 2, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{"jmp",      4'b1100, 1'b0, 1'b0, 1'b0, 1, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{"jsr_off",  4'b0100, 1'b0, 1'b1, 1'b0, 2, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{"jsrr",     4'b0100, 1'b0, 1'b0, 1'b0, 2, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{"ldr",      4'b0110, 1'b0, 1'b0, 1'b0, 5, 1, 0, 0, 3, 0, 1});
    vecs.push_back('{"str",      4'b0111, 1'b1, 1'b0, 1'b0, 5, 0, 0, 3, 0, 0, 0});
    vecs.push_back('{"op1111",   4'b1111, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"op1000",   4'b1000, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"op0010",   4'b0010, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"op1110",   4'b1110, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0});

    // Asynchronous reset from an unknown state, no clock edge needed
    Reset = 1'b1; Run = 1'b0; Continue = 1'b0; Opcode = 4'b0000;
    IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
    #2 Reset = 1'b0;
    #1 check_obs("reset_outputs", '0);
    tick();
    Reset = 1'b1;
    tick();
    check_obs("halted_hold_1", '0);
    tick();
    check_obs("halted_hold_2", '0);

    // Run from HALTED into an ADD with immediate operand; FETCH1 again on cycle 8
    Opcode = 4'b0001; IR_5 = 1'b1; Run = 1'b1;
    tick();
    check_obs("run_fetch1", fetch1_obs());
    build_trace(4'b0001, 1'b1, 1'b0, 1'b0, 1, 1);
    check_int("add_trace_len", exp_q.size(), 7);
    run_trace("add_from_halt");

    // Directed instruction table
    foreach (vecs[i]) run_vec(vecs[i]);

    // Pause: Continue low for 5 extra cycles, then high 3, then low
    Opcode = 4'b1101;
    build_trace(4'b1101, 1'b0, 1'b0, 1'b0, 6, 3);
    run_trace("pause");

    // Reset in the middle of the instruction read
    Opcode = 4'b0001; Continue = 1'b0;
    tick();
    tick();
    check_int("fetch2_2_mem_oe", int'(Mem_OE), 1);
    #2 Reset = 1'b0;
    #1 check_int("reset_mid_fetch_mem_oe", int'(Mem_OE), 0);
    check_obs("reset_mid_fetch_outputs", '0);
    Run = 1'b1;
    tick();
    tick();
    check_obs("held_in_reset", '0);
    Reset = 1'b1; Run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_obs("halted_after_release", '0);
    end
    Run = 1'b1;
    tick();
    check_obs("restart_fetch1", fetch1_obs());

    // Reset in the middle of a store write
    Opcode = 4'b0111;
    for (int i = 0; i < 9; i++) begin
      Run = 1'($urandom_range(0, 1));
      tick();
    end
    check_int("str3_2_mem_we", int'(Mem_WE), 1);
    #2 Reset = 1'b0;
    #1 check_int("reset_mid_store_mem_we", int'(Mem_WE), 0);
    tick();
    Reset = 1'b1; Run = 1'b1;
    tick();
    check_obs("restart_after_store", fetch1_obs());

    // Random instruction stream against the trace model
    for (int n = 0; n < 60; n++) begin
      op     = 4'($urandom_range(0, 15));
      Opcode = op;
      IR_5   = 1'($urandom_range(0, 1));
      IR_11  = 1'($urandom_range(0, 1));
      BEN    = 1'($urandom_range(0, 1));
      pk     = int'($urandom_range(1, 4));
      pm     = int'($urandom_range(1, 3));
      build_trace(op, IR_5, IR_11, BEN, pk, pm);
      run_trace($sformatf("rnd%0d_op%b", n, op));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slc3_control.md
SLC3_CONTROL -- requirements
Module: slc3_control

Interface
REQ-001 SHALL have ports: Clk  in  1  system clock, all state changes on rising edge.
REQ-002 SHALL have ports: Reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: Run  in  1  start from HALTED; Continue  in  1  resume from PAUSE.
REQ-004 SHALL have ports: Opcode  in  4  IR[15:12]; IR_5  in  1  immediate select; IR_11  in  1  JSR/JSRR select; BEN  in  1  latched branch-enable.
REQ-005 SHALL have 1-bit outputs LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED, GatePC, GateMDR, GateALU, GateMARMUX, SR2MUX, ADDR1MUX, DRMUX, SR1MUX, Mem_OE, Mem_WE.
REQ-006 SHALL have 2-bit outputs PCMUX, ADDR2MUX, ALUK.

Function
REQ-007 SHALL be a Moore FSM; every output is a function of current state (and of IR_5 only for SR2MUX).
REQ-008 Default per state: all LD_*, Gate*, Mem_* = 0; all muxes = 0.
REQ-009 At most one Gate* SHALL be 1 in any state (one-hot bus).
REQ-010 Encodings SHALL be: PCMUX 00=PC+1, 01=bus, 10=adder; ADDR2MUX 00=zero, 01=off6, 10=off9, 11=off11; ALUK 00=ADD, 01=AND, 10=NOT, 11=PASSA; ADDR1MUX 0=PC, 1=SR1; DRMUX 0=IR[11:9], 1=R7; SR1MUX 0=IR[11:9], 1=IR[8:6].
REQ-011 States SHALL be: HALTED, FETCH1, FETCH2_1, FETCH2_2, FETCH2_3, FETCH3, DECODE, ADD, AND, NOT, BR, BR_TAKEN, JMP, JSR, JSR_REG, JSR_OFF, LDR1, LDR2_1, LDR2_2, LDR2_3, LDR3, STR1, STR2, STR3_1, STR3_2, STR3_3, PAUSE1, PAUSE2.
REQ-012 HALTED -> FETCH1 when Run=1; else hold.
REQ-013 FETCH1: GatePC, LD_MAR, LD_PC, PCMUX=00.
REQ-014 FETCH2_1..FETCH2_3: Mem_OE=1; LD_MDR=1 in FETCH2_3 only (fixed 3-cycle memory read).
REQ-015 FETCH3: GateMDR, LD_IR. DECODE: LD_BEN; next state by Opcode.
REQ-016 Decode map: 0001 ADD, 0101 AND, 1001 NOT, 0000 BR, 1100 JMP, 0100 JSR, 0110 LDR1, 0111 STR1, 1101 PAUSE1; any other opcode -> FETCH1 (no-op).
REQ-017 ADD/AND: SR1MUX=1, SR2MUX=IR_5, ALUK=00/01, GateALU, LD_REG, LD_CC. NOT: SR1MUX=1, ALUK=10, GateALU, LD_REG, LD_CC.
REQ-018 BR -> BR_TAKEN if BEN=1 else FETCH1; BR_TAKEN: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC.
REQ-019 JMP: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC.
REQ-020 JSR: GatePC, DRMUX=1, LD_REG; next JSR_OFF if IR_11=1 else JSR_REG. JSR_OFF: ADDR1MUX=0, ADDR2MUX=11, PCMUX=10, LD_PC. JSR_REG as JMP.
REQ-021 LDR1/STR1: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR.
REQ-022 LDR2_1..3: Mem_OE, LD_MDR in LDR2_3. LDR3: GateMDR, LD_REG, LD_CC.
REQ-023 STR2: SR1MUX=0, ALUK=11, GateALU, LD_MDR. STR3_1..3: Mem_WE=1 all three cycles.
REQ-024 PAUSE1: LD_LED in first cycle only; holds until Continue=1 -> PAUSE2; PAUSE2 holds until Continue=0 -> FETCH1.
REQ-025 Every execute terminal state SHALL go to FETCH1 next cycle; Run is ignored outside HALTED.

Reset
REQ-026 Reset=0 SHALL force HALTED immediately, asynchronously, from any state including mid-memory access; outputs take HALTED defaults (all 0) without a clock.
REQ-027 After Reset release, first transition requires Run=1 at a rising edge.

Structure
REQ-028 State enum, opcode constants, and PCMUX/ADDR2MUX/ALUK encodings SHALL live in shared package slc3_pkg, also used by datapath.
REQ-029 Single module; state register plus combinational next-state/output logic; no sub-module.

Verification
REQ-030 Reset=0 mid FETCH2_2 -> state HALTED, Mem_OE=0 same cycle.
REQ-031 Run=1 from HALTED, Opcode=0001, IR_5=1 -> FETCH1..FETCH3, DECODE, ADD with SR2MUX=1, LD_REG=LD_CC=1; FETCH1 on cycle 8.
REQ-032 Opcode=0000, BEN=0 -> BR then FETCH1, LD_PC never 1; BEN=1 -> BR_TAKEN with PCMUX=10, LD_PC=1.
REQ-033 Opcode=0111 -> STR1, STR2, Mem_WE=1 for exactly 3 cycles, then FETCH1.
REQ-034 Opcode=1101, Continue=0 for 5 cycles -> PAUSE1 held, LD_LED=1 one cycle; Continue=1 then 0 -> PAUSE2 then FETCH1.
REQ-035 Opcode=1111 (unused) -> DECODE then FETCH1, no LD_REG/LD_PC asserted.
